// File: rtl/icache_direct.sv
// Read-only direct-mapped instruction cache: combinational hit path, 128-bit line refill
// from slow memory over a level-held read handshake, saturating hit/miss counters.
module icache_direct #(
  parameter int INDEX_W = 3,
  parameter int TAG_W   = 25
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         proc_read,
  input  logic [29:0]  proc_addr,
  output logic [31:0]  proc_rdata,
  output logic         proc_stall,
  output logic         mem_read,
  output logic [27:0]  mem_addr,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
);

  localparam int LINES = 1 << INDEX_W;

  typedef enum logic {IDLE, ALLOC} state_t;

  state_t             state_q, state_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [127:0]       data_q [LINES];
  logic               mem_read_q, mem_read_d;
  logic [27:0]        mem_addr_q, mem_addr_d;
  logic [15:0]        hit_count_q, hit_count_d;
  logic [15:0]        miss_count_q, miss_count_d;

  logic [INDEX_W-1:0] idx, fill_idx;
  logic [TAG_W-1:0]   tag, fill_tag;
  logic               hit, fill;

  assign idx      = proc_addr[INDEX_W+1:2];
  assign tag      = proc_addr[29:INDEX_W+2];
  // The latched line address doubles as the refill index/tag source.
  assign fill_idx = mem_addr_q[INDEX_W-1:0];
  assign fill_tag = mem_addr_q[27:INDEX_W];
  assign hit      = proc_read & valid_q[idx] & (tag_q[idx] == tag);
  assign fill     = (state_q == ALLOC) & mem_ready;

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    mem_read_d   = mem_read_q;
    mem_addr_d   = mem_addr_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    proc_stall   = 1'b0;
    proc_rdata   = '0;
    case (state_q)
      IDLE: begin
        if (hit) begin
          proc_rdata = data_q[idx][{proc_addr[1:0], 5'd0} +: 32];
          if (hit_count_q != '1) hit_count_d = hit_count_q + 16'd1;
        end else if (proc_read) begin
          proc_stall = 1'b1;
          mem_addr_d = proc_addr[29:2];
          mem_read_d = 1'b1;
          state_d    = ALLOC;
          if (miss_count_q != '1) miss_count_d = miss_count_q + 16'd1;
        end
      end
      ALLOC: begin
        proc_stall = 1'b1;
        if (mem_ready) begin
          valid_d[fill_idx] = 1'b1;
          mem_read_d        = 1'b0;
          state_d           = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      mem_read_q   <= 1'b0;
      mem_addr_q   <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      mem_read_q   <= mem_read_d;
      mem_addr_q   <= mem_addr_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Tag and data arrays carry no reset; the valid bits gate them.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_rdata;
    end
  end

  assign mem_read   = mem_read_q;
  assign mem_addr   = mem_addr_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: doc/icache_direct.md
# icache_direct

Read-only, direct-mapped instruction cache between the RISC-V core's fetch stage and the instruction slow memory (`slow_memI`) inside `CHIP`. It returns a 32-bit instruction word to the core on a hit in the same cycle. On a miss it stalls the core, fetches the whole 128-bit line from slow memory with a level-held read handshake, installs the line, and then serves the access. It has no write path; the instruction memory port is read-only.

## Interface
- `INDEX_W`, 3: index bits; number of lines = 2^INDEX_W (8).
- `TAG_W`, 25: tag bits; must equal 30 − 2 − INDEX_W.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `proc_read` in 1: core requests an instruction this cycle.
- `proc_addr` in 30: word address; [1:0] word-in-line, [INDEX_W+1:2] index, [29:INDEX_W+2] tag.
- `proc_rdata` out 32: instruction word; valid when `proc_read`=1 and `proc_stall`=0.
- `proc_stall` out 1: core must hold `proc_addr`/`proc_read` and not advance.
- `mem_read` out 1: slow-memory read request, held until `mem_ready`.
- `mem_addr` out 28: line address (byte address [31:4]).
- `mem_rdata` in 128: line data; word k = bits [32k+31:32k].
- `mem_ready` in 1: one-cycle pulse, `mem_rdata` valid this cycle.
- `hit_count` out 16: saturating hit counter.
- `miss_count` out 16: saturating miss counter.

## Operation
- Storage per line: valid bit, TAG_W tag, 128-bit data; all registers, no SRAM macro.
- hit = `proc_read` & valid[idx] & (tag[idx] == proc_addr tag field).
- FSM states: IDLE, ALLOC.
- IDLE, `proc_read`=0: `proc_stall`=0, no state change.
- IDLE, hit: `proc_stall`=0, `proc_rdata` = word `proc_addr[1:0]` of line idx (combinational); `hit_count` += 1.
- IDLE, miss: `proc_stall`=1 (combinational, same cycle); at the clock edge latch `proc_addr[29:2]` into `mem_addr`, set `mem_read`=1, and go to ALLOC; `miss_count` += 1.
- ALLOC: `proc_stall`=1; `mem_read`/`mem_addr` held stable. When `mem_ready`=1: at that edge write `mem_rdata` into the line selected by the latched index, set the tag from the latched tag, set valid=1, clear `mem_read`, and go to IDLE.
- The re-presented access after refill hits in IDLE and increments `hit_count`.
- `proc_rdata` = 32'h0 whenever not (IDLE & hit).
- Counters saturate at 16'hFFFF and never wrap.
- `mem_ready` while in IDLE is ignored: no state, data, or counter change.
- A miss replaces the indexed line unconditionally. No dirty state and no write-back.

## Timing
- Reset (`rst_n`=0, async): state=IDLE, all valid=0, `mem_read`=0, `mem_addr`=0, both counters=0. Tag and data arrays are not reset.
- While in reset, `proc_stall` = `proc_read` (every lookup misses) and `proc_rdata`=0.
- Hit latency: 0 cycles (combinational in the request cycle).
- Miss timing:
  - Cycle M is the miss. `mem_read` rises at the edge ending M.
  - Memory returns in cycle R (`mem_ready`=1); the line is installed at the edge ending R.
  - `proc_stall` is 1 from M through R inclusive. It is 0 in R+1, where the hit delivers data.
  - `mem_read` is 0 from R+1.
  - Total stall = (R − M + 1) cycles.
- `mem_addr` changes only at the M edge. It is stable for the whole request.
- Reset asserted mid-ALLOC: immediately IDLE, `mem_read`=0, all lines invalid. A later stray `mem_ready` is ignored.
- `proc_addr` changing during ALLOC (core protocol violation) does not affect the refill, which uses the latched address.

## Test plan
- Reset then idle: `rst_n` low 8 cycles, `proc_read`=0 -> `mem_read`=0, `mem_addr`=0, counters 0, `proc_stall`=0.
- Cold miss: `proc_addr`=30'h4, slow memory returns line {32'hD,32'hC,32'hB,32'hA} 5 cycles after `mem_read` -> `mem_addr`=28'h1, stall 6+ cycles, then `proc_rdata`=32'hA; `miss_count`=1, `hit_count`=1.
- Same-line hits: after the cold miss, addresses 30'h5, 30'h6, 30'h7 on consecutive cycles -> 32'hB, 32'hC, 32'hD, no stall, `hit_count`=4.
- Conflict: access 30'h24 (same index 1, different tag) -> miss, `mem_addr`=28'h9; then 30'h4 misses again -> `miss_count`=3.
- Reset mid-refill: assert `rst_n`=0 in ALLOC, release, drive `mem_ready`=1 -> no line installed, and re-access of 30'h4 misses.
- Saturation: force 65 540 hits on one line -> `hit_count` stays 16'hFFFF.
